// File: rtl/byte_link_pkg.sv
// rtl/byte_link_pkg.sv - shared header layout and FSM state types for byte_link_mux
package byte_link_pkg;

    localparam int HDR_WR     = 7;
    localparam int HDR_CH_LSB = 0;
    localparam int HDR_CH_W   = 4;

    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_ADDR, TX_DATA} tx_state_e;
    typedef enum logic [1:0] {RX_HDR, RX_DATA, RX_DLV} rx_state_e;

    function automatic logic [7:0] make_hdr(input logic wr, input logic [HDR_CH_W-1:0] ch);
        logic [7:0] h;
        h = 8'h00;
        h[HDR_WR] = wr;
        h[HDR_CH_LSB +: HDR_CH_W] = ch;
        return h;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, pointer moves past the winner on accept
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;

    // First pass searches ptr..N-1; if empty, any remaining request lies below ptr.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                win      = PW'(i);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                win      = PW'(i);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/byte_link_mux.sv
// rtl/byte_link_mux.sv - multi-channel request arbiter and tagged response router over a byte FIFO pair
module byte_link_mux #(
    parameter int NCH    = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req_valid,
    input  logic [NCH-1:0]        req_write,
    input  logic [NCH*ADDR_W-1:0] req_addr,
    input  logic [NCH*DATA_W-1:0] req_wdata,
    output logic [NCH-1:0]        req_ready,
    output logic [NCH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    input  logic                  cmd_almost_full,
    output logic                  cmd_wr_en,
    output logic [7:0]            cmd_dout,
    input  logic                  res_almost_empty,
    output logic                  res_rd_en,
    input  logic [7:0]            res_din
);
    import byte_link_pkg::*;

    localparam int AB = ADDR_W / 8;
    localparam int DB = DATA_W / 8;

    logic [NCH-1:0]    outst;
    logic [NCH-1:0]    grant;
    logic              tx_accept;
    logic              tx_emit;
    tx_state_e         tx_state, tx_next;
    logic [7:0]        tx_cnt, tx_cnt_next;
    logic [7:0]        tx_byte;
    logic              tx_write;
    logic [3:0]        tx_ch;
    logic [ADDR_W-1:0] tx_addr;
    logic [DATA_W-1:0] tx_data;
    logic              g_write;
    logic [3:0]        g_ch;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;

    rx_state_e         rx_state;
    logic [7:0]        rx_cnt;
    logic [7:0]        rd_cnt;
    logic              rd_pend;
    logic [3:0]        rx_tag;
    logic              rx_bad;
    logic [DATA_W-1:0] rx_word;
    logic [NCH-1:0]    dlv;
    logic              err;

    rr_arbiter #(.N(NCH)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid & ~outst),
        .accept (tx_accept),
        .grant  (grant)
    );

    always_comb begin
        g_write = 1'b0;
        g_ch    = '0;
        g_addr  = '0;
        g_data  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                g_write = req_write[i];
                g_ch    = 4'(i);
                g_addr  = req_addr[i*ADDR_W +: ADDR_W];
                g_data  = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign tx_accept = !rst && (tx_state == TX_IDLE) && (|grant);
    assign req_ready = tx_accept ? grant : '0;
    assign tx_emit   = !rst && (tx_state != TX_IDLE) && !cmd_almost_full;
    assign cmd_wr_en = tx_emit;
    assign cmd_dout  = tx_emit ? tx_byte : 8'h00;

    // Address and data are shifted out LSB first, so the current byte is always [7:0].
    always_comb begin
        tx_next     = tx_state;
        tx_cnt_next = tx_cnt;
        tx_byte     = 8'h00;
        case (tx_state)
            TX_IDLE: if (tx_accept) tx_next = TX_HDR;
            TX_HDR: begin
                tx_byte = make_hdr(tx_write, tx_ch);
                if (tx_emit) begin
                    tx_next     = TX_ADDR;
                    tx_cnt_next = 8'd0;
                end
            end
            TX_ADDR: begin
                tx_byte = tx_addr[7:0];
                if (tx_emit) begin
                    if (tx_cnt == 8'(AB - 1)) begin
                        tx_cnt_next = 8'd0;
                        tx_next     = tx_write ? TX_DATA : TX_IDLE;
                    end else begin
                        tx_cnt_next = tx_cnt + 8'd1;
                    end
                end
            end
            TX_DATA: begin
                tx_byte = tx_data[7:0];
                if (tx_emit) begin
                    if (tx_cnt == 8'(DB - 1)) begin
                        tx_cnt_next = 8'd0;
                        tx_next     = TX_IDLE;
                    end else begin
                        tx_cnt_next = tx_cnt + 8'd1;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 8'd0;
            tx_write <= 1'b0;
            tx_ch    <= '0;
            tx_addr  <= '0;
            tx_data  <= '0;
            outst    <= '0;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= tx_cnt_next;
            outst    <= (outst | req_ready) & ~rsp_valid;
            if (tx_accept) begin
                tx_write <= g_write;
                tx_ch    <= g_ch;
                tx_addr  <= g_addr;
                tx_data  <= g_data;
            end
            if (tx_emit && tx_state == TX_ADDR) tx_addr <= tx_addr >> 8;
            if (tx_emit && tx_state == TX_DATA) tx_data <= tx_data >> 8;
        end
    end

    // Reads are budgeted per frame so a strobe never pulls a byte of the next frame early.
    assign res_rd_en = !rst && (rd_cnt != 8'(DB + 1)) && !res_almost_empty;

    always_comb begin
        dlv = '0;
        for (int i = 0; i < NCH; i++) begin
            dlv[i] = !rst && (rx_state == RX_DLV) && !rx_bad && (rx_tag == 4'(i)) && outst[i];
        end
    end

    assign rsp_valid = dlv;
    assign rsp_data  = (|dlv) ? rx_word : '0;
    assign rsp_err   = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_HDR;
            rx_cnt   <= 8'd0;
            rd_cnt   <= 8'd0;
            rd_pend  <= 1'b0;
            rx_tag   <= '0;
            rx_bad   <= 1'b0;
            rx_word  <= '0;
            err      <= 1'b0;
        end else begin
            rd_pend <= res_rd_en;
            if (res_rd_en) rd_cnt <= rd_cnt + 8'd1;
            case (rx_state)
                RX_HDR: if (rd_pend) begin
                    rx_tag   <= res_din[HDR_CH_LSB +: HDR_CH_W];
                    rx_bad   <= (res_din[6:4] != 3'b000) ||
                                ({1'b0, res_din[HDR_CH_LSB +: HDR_CH_W]} >= 5'(NCH));
                    rx_cnt   <= 8'd0;
                    rx_state <= RX_DATA;
                end
                RX_DATA: if (rd_pend) begin
                    rx_word <= (rx_word >> 8) | (DATA_W'(res_din) << (DATA_W - 8));
                    if (rx_cnt == 8'(DB - 1)) rx_state <= RX_DLV;
                    else                      rx_cnt   <= rx_cnt + 8'd1;
                end
                RX_DLV: begin
                    if (dlv == '0) err <= 1'b1;
                    rd_cnt   <= 8'd0;
                    rx_state <= RX_HDR;
                end
                default: rx_state <= RX_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_link_mux.sv
// tb/tb_byte_link_mux.sv - scoreboard bench for byte_link_mux with a behavioural FIFO pair
module tb_byte_link_mux;
    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_write;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic              cmd_almost_full;
    logic              cmd_wr_en;
    logic [7:0]        cmd_dout;
    logic              res_almost_empty;
    logic              res_rd_en;
    logic [7:0]        res_din;

    int          errors = 0;
    int          checks = 0;
    int          cmd_seen = 0;
    logic [7:0]  cmd_q[$];
    int          grant_q[$];
    rsp_t        rsp_q[$];
    logic [7:0]  res_q[$];

    always #5 clk = ~clk;

    byte_link_mux #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .cmd_almost_full  (cmd_almost_full),
        .cmd_wr_en        (cmd_wr_en),
        .cmd_dout         (cmd_dout),
        .res_almost_empty (res_almost_empty),
        .res_rd_en        (res_rd_en),
        .res_din          (res_din)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h with nothing expected at %0t", name, act, $time);
    endtask

    // Monitor: compare every strobe the DUT presents against the scoreboard queues.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (cmd_almost_full) chk("cmd_stall", cmd_wr_en, 0);
            if (cmd_wr_en) begin
                cmd_seen++;
                if (cmd_q.size() == 0) unexpected("cmd_byte", cmd_dout);
                else chk("cmd_byte", cmd_dout, cmd_q.pop_front());
            end
            if (|req_ready) begin
                if (grant_q.size() == 0) unexpected("grant", req_ready);
                else chk("grant", req_ready, 64'(1) << grant_q.pop_front());
            end
            if (|rsp_valid) begin
                if (rsp_q.size() == 0) unexpected("rsp_valid", rsp_valid);
                else begin
                    r = rsp_q.pop_front();
                    chk("rsp_valid", rsp_valid, 64'(1) << r.ch);
                    chk("rsp_data", rsp_data, r.data);
                end
            end
        end
    end

    // Response FIFO model: byte appears the cycle after the read strobe.
    initial begin
        logic rd;
        forever begin
            @(negedge clk);
            rd = res_rd_en;
            @(posedge clk);
            #1;
            if (rd) begin
                if (res_q.size() == 0) unexpected("res_read_empty", 1);
                else res_din = res_q.pop_front();
            end
            res_almost_empty = (res_q.size() == 0);
        end
    end

    // Masters drop their request once they have seen req_ready.
    initial begin
        logic [NCH-1:0] r;
        forever begin
            @(negedge clk);
            r = req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~r;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_cmd(input int ch, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        grant_q.push_back(ch);
        cmd_q.push_back({wr, 3'b000, 4'(ch)});
        for (int b = 0; b < AW / 8; b++) cmd_q.push_back(addr[8*b +: 8]);
        if (wr) for (int b = 0; b < DW / 8; b++) cmd_q.push_back(data[8*b +: 8]);
    endtask

    task automatic drive_req(input int ch, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        req_write[ch]          = wr;
        req_addr[ch*AW +: AW]  = addr;
        req_wdata[ch*DW +: DW] = data;
        req_valid[ch]          = 1'b1;
    endtask

    task automatic issue(input int ch, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        exp_cmd(ch, wr, addr, data);
        drive_req(ch, wr, addr, data);
    endtask

    task automatic feed(input logic [7:0] hdr, input logic [31:0] data);
        res_q.push_back(hdr);
        for (int b = 0; b < DW / 8; b++) res_q.push_back(data[8*b +: 8]);
        res_almost_empty = 1'b0;
    endtask

    task automatic expect_rsp(input int ch, input logic [31:0] data);
        rsp_t r;
        r.ch   = ch;
        r.data = data;
        rsp_q.push_back(r);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((cmd_q.size() + grant_q.size() + rsp_q.size() + res_q.size()) != 0 && n < 300) begin
            step();
            n++;
        end
        step(2);
        chk(name, n < 300, 1);
    endtask

    task automatic wait_bytes(input int target);
        int n = 0;
        while (cmd_seen < target && n < 100) begin
            step();
            n++;
        end
        chk("wait_bytes", n < 100, 1);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_req_ready"}, req_ready, 0);
        chk({name, "_rsp_valid"}, rsp_valid, 0);
        chk({name, "_rsp_data"}, rsp_data, 0);
        chk({name, "_rsp_err"}, rsp_err, 0);
        chk({name, "_cmd_wr_en"}, cmd_wr_en, 0);
        chk({name, "_cmd_dout"}, cmd_dout, 0);
        chk({name, "_res_rd_en"}, res_rd_en, 0);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr = '0;
        req_wdata = '0;
        cmd_almost_full = 1'b0;
        res_almost_empty = 1'b1;
        res_din = 8'h00;
        step(3);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2);

        // All four channels at once: grants 0,1,2,3; ch0 re-request waits for its response.
        issue(0, 1'b0, 32'h0000_0100, 32'h0);
        issue(1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D);
        issue(2, 1'b0, 32'h0000_0300, 32'h0);
        issue(3, 1'b0, 32'h0000_0400, 32'h0);
        drain("all4_tx");
        drive_req(0, 1'b0, 32'h0000_0500, 32'h0);
        step(10);
        feed(8'h01, 32'h0000_0000); expect_rsp(1, 32'h0000_0000);
        feed(8'h02, 32'hDDCC_BBAA); expect_rsp(2, 32'hDDCC_BBAA);
        feed(8'h03, 32'h8000_0001); expect_rsp(3, 32'h8000_0001);
        drain("all4_rsp");
        exp_cmd(0, 1'b0, 32'h0000_0500, 32'h0);
        feed(8'h00, 32'h4433_2211); expect_rsp(0, 32'h4433_2211);
        drain("ch0_retry");
        feed(8'h00, 32'h00FF_A55A); expect_rsp(0, 32'h00FF_A55A);
        drain("ch0_retry_rsp");

        // Single read on ch0.
        issue(0, 1'b0, 32'h0000_1000, 32'h0);
        drain("read_tx");
        feed(8'h00, 32'hDEAD_BEEF); expect_rsp(0, 32'hDEAD_BEEF);
        drain("read_rsp");

        // Write on ch2.
        issue(2, 1'b1, 32'h0000_0010, 32'h1122_3344);
        drain("write_tx");
        feed(8'h02, 32'h0403_0201); expect_rsp(2, 32'h0403_0201);
        drain("write_rsp");

        // Backpressure for 5 cycles in the middle of the address bytes.
        base = cmd_seen;
        issue(1, 1'b0, 32'h0403_0201, 32'h0);
        wait_bytes(base + 3);
        cmd_almost_full = 1'b1;
        step(5);
        cmd_almost_full = 1'b0;
        drain("stall_tx");
        chk("stall_len", cmd_seen - base, 5);
        feed(8'h01, 32'h0BAD_F00D); expect_rsp(1, 32'h0BAD_F00D);
        drain("stall_rsp");

        // Response for a non-outstanding channel, then a legitimate one.
        chk("err_before", rsp_err, 0);
        issue(1, 1'b0, 32'h0000_0044, 32'h0);
        drain("stray_tx");
        feed(8'h03, 32'hFFFF_FFFF);
        feed(8'h01, 32'hA5A5_5A5A); expect_rsp(1, 32'hA5A5_5A5A);
        drain("stray_rsp");
        chk("err_after", rsp_err, 1);

        // Reset while the address bytes are going out.
        base = cmd_seen;
        issue(0, 1'b0, 32'hAABB_CCDD, 32'h0);
        wait_bytes(base + 2);
        rst = 1'b1;
        step();
        @(negedge clk);
        check_idle_outputs("midreset");
        @(posedge clk);
        #1;
        cmd_q.delete();
        rst = 1'b0;
        step(2);
        issue(0, 1'b0, 32'h0000_0020, 32'h0);
        drain("post_reset_tx");
        feed(8'h00, 32'h1234_5678); expect_rsp(0, 32'h1234_5678);
        drain("post_reset_rsp");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/byte_link_mux.md
# byte_link_mux

Parametrised, multi-channel successor to the single-master ROM front end. It arbitrates NCH independent request channels onto one byte stream written into the command FIFO, and parses the response byte stream read from the response FIFO. Each response is routed back to the issuing channel by a channel tag. It sits between bus-side masters (e.g. stimulator, tilelink adapters) and the FTDI-side FIFO pair, all in the `clk` domain.

## Interface
- NCH, 4: number of request channels, 1..16
- ADDR_W, 32: address width, multiple of 8
- DATA_W, 32: data width, multiple of 8
- clk  in  1  system clock; one clock only
- rst  in  1  synchronous, active-high reset
- req_valid  in  NCH  per-channel request valid
- req_write  in  NCH  1 = write, 0 = read
- req_addr  in  NCH*ADDR_W  packed addresses; channel i occupies [i*ADDR_W +: ADDR_W]
- req_wdata  in  NCH*DATA_W  packed write data
- req_ready  out  NCH  one-hot, one-cycle accept pulse
- rsp_valid  out  NCH  one-hot, one-cycle response pulse
- rsp_data  out  DATA_W  response data, valid while any rsp_valid bit is high
- rsp_err  out  1  sticky error flag; cleared only by rst
- cmd_almost_full  in  1  command FIFO cannot take a byte
- cmd_wr_en  out  1  command FIFO write strobe
- cmd_dout  out  8  command byte
- res_almost_empty  in  1  response FIFO has no byte
- res_rd_en  out  1  response FIFO read strobe
- res_din  in  8  response byte; valid one cycle after res_rd_en

## Operation
- Header byte: [7] write, [6:4] 0, [3:0] channel id.
- Command frame: header, then ADDR_W/8 address bytes LSB first, then DATA_W/8 data bytes LSB first (writes only).
- Response frame: header, then DATA_W/8 data bytes LSB first. Writes return this frame too; their data is ignored by masters.
- Outstanding vector, one bit per channel: set on accept, cleared on rsp_valid. A channel with its bit set is masked from arbitration, so each channel has at most one request in flight.
- TX FSM states:
  - TX_IDLE: round-robin arbitration over req_valid & ~outstanding. The pointer starts at channel 0 and moves to the winner+1 after each grant. The winner gets req_ready and its fields are latched.
  - TX_HDR -> TX_ADDR -> TX_DATA (writes only) -> TX_IDLE.
  - Each state emits one byte per cycle in which cmd_almost_full=0. A byte counter is indexed by byte number. No byte is ever written while cmd_almost_full=1.
- RX FSM states:
  - RX_HDR: issue res_rd_en whenever res_almost_empty=0; consume the byte next cycle.
  - RX_DATA: collect DATA_W/8 bytes the same way.
  - RX_DLV: if the tag's outstanding bit is set, pulse rsp_valid[tag] with the assembled word. Otherwise set rsp_err and drop the frame. Then return to RX_HDR.
- Tag >= NCH or header bits [6:4] != 0: set rsp_err, still consume DATA_W/8 bytes to keep framing.
- TX and RX run concurrently. Grant and delivery in the same cycle on different channels are both honoured. The same channel cannot do both, because its outstanding bit blocks the grant.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, cmd_wr_en=0, cmd_dout=0, res_rd_en=0. Both FSMs go to IDLE/HDR, the outstanding vector clears, and the RR pointer returns to 0.
- Reset mid-frame abandons the partial frame. Bytes already written into or read from the FIFOs are not recovered.
- Accept: req_ready is high in cycle T and the request sees it the same cycle. The header byte is written in T+1 at the earliest.
- Command frame length with no backpressure: 1+ADDR_W/8 (+DATA_W/8) cycles, back to back. The next grant can occur in the cycle after the last byte.
- Response path: from the last data byte arriving, rsp_valid follows 1 cycle later. Best-case header-read to rsp_valid is DATA_W/8+2 cycles.
- res_rd_en is never asserted in two consecutive cycles whose second byte would overflow the current frame. Each read strobe maps to exactly one consumed byte.

## Structure
- Package byte_link_pkg holds:
  - header bit positions (HDR_WR=7, HDR_CH_LSB=0, HDR_CH_W=4)
  - tx_state_e {TX_IDLE, TX_HDR, TX_ADDR, TX_DATA}
  - rx_state_e {RX_HDR, RX_DATA, RX_DLV}
- Sub-module rr_arbiter (parameter N): request vector in, one-hot grant out, pointer advanced on an accept strobe.

## Test plan
- Single read, ch0, addr 0x0000_1000, NCH=4: cmd bytes 00,00,10,00,00. Feed response 00,EF,BE,AD,DE -> rsp_valid[0] with rsp_data=0xDEADBEEF.
- Write, ch2, addr 0x10, data 0x11223344: cmd bytes 82,10,00,00,00,44,33,22,11. Response 02+4 bytes -> rsp_valid[2].
- All four channels request at once: grant order 0,1,2,3. A second request on ch0 waits until ch0's response; ch1..3 are not blocked.
- Hold cmd_almost_full high for 5 cycles mid-address: no cmd_wr_en during the stall, and the byte sequence is unchanged.
- Response tagged ch3 while ch3 is not outstanding, then a valid ch1 response: rsp_err=1, no rsp_valid[3], ch1 still delivered correctly.
- Assert rst during TX_ADDR: all outputs 0 next cycle. A new ch0 read afterwards produces a correct frame.
